// File: rtl/fmac_pkg.sv
// fmac_pkg: shared widths, constants and bundles
// for the floating-point multiply-accumulate datapath.
package fmac_pkg;

    localparam int PRECISION = 34;
    localparam int MUL_LAT   = 2;
    localparam int ADD_LAT   = 1;

    localparam logic [PRECISION-1:0] FP_ZERO = '0;

    typedef struct packed {
        logic [PRECISION-1:0] a;
        logic [PRECISION-1:0] b;
        logic                 last;
    } pair_t;

    typedef struct packed {
        logic valid;
        logic last;
        logic first;
    } trk_t;

endpackage

// File: rtl/fmac_pair_fifo.sv
// fmac_pair_fifo: synchronous operand-pair FIFO,
// pointers carry one extra wrap bit for full/empty.
module fmac_pair_fifo
    import fmac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  pair_t din,
    output pair_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fmac_pair_fifo: DEPTH must be a power of two >= 2");
    end

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    pair_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; power-of-two depth wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Store pushed pairs; a push while full only happens alongside a pop.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fmac_stream_issue.sv
// fmac_stream_issue: data-driven issue of operand pairs into
// fmul/fadd, accumulating each vector into one result.
module fmac_stream_issue #(
    parameter int PRECISION = fmac_pkg::PRECISION,
    parameter int DEPTH     = 4,
    parameter int MUL_LAT   = fmac_pkg::MUL_LAT,
    parameter int ADD_LAT   = fmac_pkg::ADD_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRECISION-1:0] in_a,
    input  logic [PRECISION-1:0] in_b,
    input  logic                 in_last,
    output logic [PRECISION-1:0] fmul_x,
    output logic [PRECISION-1:0] fmul_y,
    output logic                 fmul_ce,
    input  logic [PRECISION-1:0] fmul_r,
    output logic [PRECISION-1:0] fadd_x,
    output logic [PRECISION-1:0] fadd_y,
    output logic                 fadd_ce,
    input  logic [PRECISION-1:0] fadd_r,
    output logic                 res_valid,
    output logic [PRECISION-1:0] res_data,
    input  logic                 res_ready
);

    import fmac_pkg::*;

    if (ADD_LAT != 1) begin : g_bad_add_lat
        $error("fmac_stream_issue: only ADD_LAT == 1 is supported");
    end
    if (MUL_LAT < 1) begin : g_bad_mul_lat
        $error("fmac_stream_issue: MUL_LAT must be >= 1");
    end
    if (PRECISION != fmac_pkg::PRECISION) begin : g_bad_prec
        $error("fmac_stream_issue: PRECISION must match fmac_pkg");
    end

    pair_t head;
    pair_t din;
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    logic  gate;
    logic  first_q;
    logic  add_last;
    logic  last_in_flight;
    trk_t  trk [MUL_LAT];
    trk_t  tail;

    assign din  = '{a: in_a, b: in_b, last: in_last};
    assign tail = trk[MUL_LAT-1];

    // A pending last anywhere between issue and result load.
    always_comb begin
        last_in_flight = add_last;
        for (int i = 0; i < MUL_LAT; i++) begin
            last_in_flight = last_in_flight | (trk[i].valid & trk[i].last);
        end
    end

    assign gate = !head.last
               || (!last_in_flight && (!res_valid || res_ready));
    assign pop      = !reset && !empty && gate;
    assign in_ready = !reset && (!full || pop);
    assign push     = in_valid && in_ready;

    fmac_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign fmul_ce = !reset;
    assign fadd_ce = !reset && tail.valid;
    assign fadd_y  = fadd_ce ? fmul_r : FP_ZERO;
    assign fadd_x  = (fadd_ce && !tail.first) ? fadd_r : FP_ZERO;

    // Present the issued pair to the free-running multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            fmul_x <= FP_ZERO;
            fmul_y <= FP_ZERO;
        end else if (pop) begin
            fmul_x <= head.a;
            fmul_y <= head.b;
        end
    end

    // Track each issued pair until its product reaches fmul_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) trk[i] <= '0;
            first_q  <= 1'b1;
            add_last <= 1'b0;
        end else begin
            trk[0] <= '{valid: pop,
                        last:  pop & head.last,
                        first: pop & first_q};
            for (int i = 1; i < MUL_LAT; i++) trk[i] <= trk[i-1];
            if (pop) first_q <= head.last;
            add_last <= tail.valid & tail.last;
        end
    end

    // Capture the finished sum; a new load wins over a consumer clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= FP_ZERO;
        end else if (add_last) begin
            res_valid <= 1'b1;
            res_data  <= fadd_r;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
